// File: rtl/hazard_controller.sv
// Pipeline hazard controller for a 5-stage MIPS-style core with a multicycle
// multiply/divide unit.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   rsD, rtD                    decode-stage source registers
//   writeRegisterE/M            execute/memory destination registers
//   regWriteE, memToRegE/M      execute/memory stage controls
//   branchD, jumpRegD           decode compares registers (branch or jr)
//   pcSrcD                      taken branch/jump resolved in decode
//   hiloReadD, mdStartD         decode reads HI/LO or is mult/div
//   mdStartE, mdIsDivE          mult/div issue from execute, 1=divide
//   stallF, stallD, flushE      hold PC and IF-ID, clear ID-EX
//   flushD                      clear IF-ID on a taken control transfer
//   mdBusy, mdDone, mdErr       multicycle unit status, done strobe, sticky error
//   stallCount                  saturating count of stalled cycles
module hazard_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  writeRegisterE,
  input  logic [4:0]  writeRegisterM,
  input  logic        regWriteE,
  input  logic        memToRegE,
  input  logic        memToRegM,
  input  logic        branchD,
  input  logic        jumpRegD,
  input  logic        pcSrcD,
  input  logic        hiloReadD,
  input  logic        mdStartD,
  input  logic        mdStartE,
  input  logic        mdIsDivE,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        mdBusy,
  output logic        mdDone,
  output logic        mdErr,
  output logic [15:0] stallCount
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Counter preloads: BUSY spans preload+1 cycles.
  localparam logic [4:0] DivLoad = 5'd31;
  localparam logic [4:0] MulLoad = 5'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  md_cnt_q, md_cnt_d;
  logic        md_err_q, md_err_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic lw_stall, br_stall, md_stall, stall;
  logic rs_hit, rt_hit;

  always_comb begin
    lw_stall = memToRegE && (writeRegisterE != 5'd0) &&
               ((writeRegisterE == rsD) || (writeRegisterE == rtD));

    // Register 0 is hardwired, so a match on it is never a real dependence.
    rs_hit = (rsD != 5'd0) &&
             ((regWriteE && (writeRegisterE == rsD)) ||
              (memToRegM && (writeRegisterM == rsD)));
    rt_hit = (rtD != 5'd0) &&
             ((regWriteE && (writeRegisterE == rtD)) ||
              (memToRegM && (writeRegisterM == rtD)));
    br_stall = (branchD || jumpRegD) && (rs_hit || rt_hit);

    md_stall = (state_q == StBusy) && (hiloReadD || mdStartD);
    stall    = lw_stall || br_stall || md_stall;
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_err_d = md_err_q;
    case (state_q)
      StIdle: begin
        if (mdStartE) begin
          md_cnt_d = mdIsDivE ? DivLoad : MulLoad;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // A second start while busy is dropped and flagged.
        if (mdStartE) md_err_d = 1'b1;
        if (md_cnt_q == 5'd0) begin
          state_d = StDone;
        end else begin
          md_cnt_d = md_cnt_q - 5'd1;
        end
      end
      StDone: begin
        if (mdStartE) begin
          md_cnt_d = mdIsDivE ? DivLoad : MulLoad;
          state_d  = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      md_cnt_q      <= 5'd0;
      md_err_q      <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      md_err_q      <= md_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stallF     = stall;
  assign stallD     = stall;
  assign flushE     = stall;
  assign flushD     = pcSrcD && !stall;
  assign mdBusy     = (state_q == StBusy);
  assign mdDone     = (state_q == StDone);
  assign mdErr      = md_err_q;
  assign stallCount = stall_count_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
- REQ-001 SHALL have exactly one clock and one reset: clock is clk; reset is rst, synchronous, active-high.
- REQ-002 Ports, listed as name, direction, width, meaning:
  - clk  in  1  clock
  - rst  in  1  sync active-high reset
  - rsD, rtD  in  5  decode-stage source registers
  - writeRegisterE, writeRegisterM  in  5  execute/memory destination registers
  - regWriteE, memToRegE, memToRegM  in  1  execute/memory stage controls
  - branchD, jumpRegD  in  1  decode-stage branch or jr compares registers
  - pcSrcD  in  1  taken branch/jump resolved in decode
  - hiloReadD  in  1  decode instruction reads HI/LO (mfhi/mflo)
  - mdStartD  in  1  decode instruction is mult/div
  - mdStartE  in  1  mult/div issues from execute this cycle
  - mdIsDivE  in  1  1=divide, 0=multiply
  - stallF, stallD  out  1  hold PC / IF-ID register
  - flushD, flushE  out  1  clear IF-ID / ID-EX register
  - mdBusy  out  1  multicycle unit busy
  - mdDone  out  1  one-cycle HI/LO write strobe
  - mdErr  out  1  sticky protocol error
  - stallCount  out  16  saturating count of stalled cycles

Function
- REQ-003 lwStall SHALL be 1 iff memToRegE and writeRegisterE!=0 and (writeRegisterE==rsD or writeRegisterE==rtD).
- REQ-004 brStall SHALL be 1 iff (branchD or jumpRegD) and for a nonzero match on rsD or rtD, either (regWriteE and writeRegisterE matches) or (memToRegM and writeRegisterM matches).
- REQ-005 mdStall SHALL be 1 iff state==BUSY and (hiloReadD or mdStartD).
- REQ-006 stall = lwStall|brStall|mdStall, combinational, same cycle. stallF=stallD=stall.
- REQ-007 flushE SHALL equal stall.
- REQ-008 flushD SHALL be pcSrcD & ~stall.
- REQ-009 FSM SHALL have the states IDLE, BUSY and DONE, with a 5-bit down-counter mdCnt.
  - IDLE: when mdStartE=1, load mdCnt with 31 if mdIsDivE, else 3, and go to BUSY.
  - BUSY: decrement mdCnt each cycle. When mdCnt==0, go to DONE.
  - Result: BUSY lasts 4 cycles for multiply and 32 cycles for divide.
- REQ-010 DONE SHALL last exactly one cycle with mdDone=1.
  - If mdStartE=1 in DONE, reload mdCnt per REQ-009 and go to BUSY.
  - Otherwise go to IDLE.
- REQ-011 mdBusy SHALL be 1 iff state==BUSY, registered.
- REQ-012 If mdStartE=1 while in BUSY, the start SHALL be ignored.
  - The counter and state are unaffected.
  - mdErr SHALL set on the next edge and hold until rst.
- REQ-013 stallCount SHALL increment by 1 on each clock edge where stall=1.
  - It saturates at 16'hFFFF; no wrap.
- REQ-014 Register 0 SHALL never cause a stall (REQ-003/004 nonzero qualifiers).
- REQ-015 Simultaneous lwStall and mdStall SHALL produce a single stall; flushE=1 and stallCount increments once.

Reset
- REQ-016 When rst=1 on a clock edge, the next state SHALL be:
  - state=IDLE, mdCnt=0, mdBusy=0, mdDone=0, mdErr=0, stallCount=0.
- REQ-017 Reset SHALL override every other input, including mid-BUSY and mdStartE=1.
  - No mdDone SHALL be produced for an aborted operation.
- REQ-018 Combinational outputs (stallF, stallD, flushD, flushE) SHALL follow REQ-003..008 during reset, with mdStall=0 since state=IDLE.

Verification
- REQ-019 Load-use: memToRegE=1, writeRegisterE=8, rsD=8 -> stallF=stallD=flushE=1 in the same cycle; stallCount 0->1.
- REQ-020 Branch hazard: branchD=1, rtD=9, regWriteE=1, writeRegisterE=9 -> stall=1. Next cycle memToRegM=1, writeRegisterM=9 -> stall=1. Same stimulus with register 0 -> stall=0.
- REQ-021 Divide: mdStartE=1, mdIsDivE=1 at cycle t -> mdBusy=1 for cycles t+1..t+32, mdDone=1 at t+33, then IDLE. hiloReadD=1 during BUSY -> stall=1; during DONE -> stall=0.
- REQ-022 Back-to-back: multiply, then mdStartE=1 in DONE -> immediate re-entry to BUSY for 4 cycles. mdStartE=1 during BUSY -> ignored, mdErr=1 next cycle and stays 1.
- REQ-023 Reset mid-op: rst=1 at BUSY cycle 10 of a divide -> next cycle IDLE, mdBusy=0, mdErr=0, stallCount=0, no mdDone ever produced.
- REQ-024 Saturation and flush: hold stall=1 for 65540 cycles -> stallCount=16'hFFFF. pcSrcD=1 with stall=0 -> flushD=1; pcSrcD=1 with stall=1 -> flushD=0.
